tinynpu_layer_ctrl: RTL and testbench
=====================================

// Module: tinynpu_layer_ctrl
// PURPOSE
//  Multi-layer control FSM for the TinyNPU systolic datapath. Sequences the
//  full inference loop: operand load, MAC streaming, pipeline drain and output
//  handshake. Repeats this loop for N layers, feeding each layer's output back
//  as the next layer's X operand. Sits between the host load interface and the
//  datapath FIFOs/PE array, using the existing d2c_*/c2d_* signal naming.
// PARAMETERS
//  SIZE     4  PE array dimension; number of W FIFOs
//  MAC_LAT  3  cycles from last streamed beat to valid PE output (>=1)
//  LAYER_W  4  width of layer count / layer index
// PORTS
//  clk               in   1             clock, rising edge
//  rst               in   1             synchronous active-high reset
//  d2c_x_load_val    in   1             host X word valid
//  d2c_w_load_val    in   1             host W word valid
//  d2c_w_load_sel    in   $clog2(SIZE)  target W FIFO index
//  d2c_mac_val       in   1             start compute for current layer
//  d2c_num_layers    in   LAYER_W       layer count, sampled on first start
//  d2c_x_fifo_empty  in   1             X FIFO empty
//  d2c_w_fifo_empty  in   SIZE          per-W-FIFO empty flags
//  d2c_ostream_rdy   in   1             downstream accepts output
//  c2d_x_sel         out  1             0 = host X, 1 = feedback X
//  c2d_x_fifo_wen    out  1             X FIFO write enable
//  c2d_w_fifo_wen    out  SIZE          one-hot W FIFO write enable
//  c2d_istream_val   out  1             PE input stream valid
//  c2d_x_fifo_ren    out  1             X FIFO read enable
//  c2d_w_fifo_ren    out  1             W FIFO read enable (all FIFOs)
//  c2d_ostream_req   out  1             output valid / request
//  c2d_acc_clr       out  1             clear PE accumulators
//  c2d_done          out  1             1-cycle pulse: all layers finished
//  c2d_layer_idx     out  LAYER_W       current layer index
//  trace_state       out  3             current FSM state encoding
// BEHAVIOUR
//  States: LOAD=0, MAC=1, DRAIN=2, OUT=3, DONE=4. Registered state.
//  Outputs are combinational from state and inputs.
//  Reset: state=LOAD, layer_idx=0, num_layers_q=1, drain_cnt=0.
//   With idle inputs, every output is 0 in the cycle after rst.
//   rst mid-operation aborts all activity. No output pulses during rst.
//  LOAD: c2d_x_sel = (layer_idx!=0).
//   c2d_x_fifo_wen = x_load_val.
//   c2d_w_fifo_wen[i] = w_load_val & (w_load_sel==i).
//   d2c_mac_val=1 -> MAC next cycle. If layer_idx==0, capture num_layers.
//   A captured num_layers of 0 is treated as 1.
//   Load and start in the same cycle: the write still occurs.
//  Outside LOAD: all wen=0. Load valids and mac_val are ignored.
//  MAC: all_empty = x_empty & all w_empty; any_empty = OR of the same flags.
//   ~any_empty: istream_val = x_ren = w_ren = 1 (one beat per cycle).
//   any_empty & ~all_empty: stall with all three outputs at 0; stay in MAC.
//   all_empty: go to DRAIN; drain_cnt cleared.
//  DRAIN: drain_cnt increments each cycle. Stay exactly MAC_LAT cycles.
//   Leave for OUT when drain_cnt==MAC_LAT-1.
//  OUT: c2d_ostream_req=1. Hold while d2c_ostream_rdy=0 (no timeout).
//   Handshake cycle (req & rdy): c2d_acc_clr=1.
//   If layer_idx+1 < num_layers_q: layer_idx++, next state LOAD.
//   Otherwise: next state DONE.
//  DONE: c2d_done=1 for one cycle, layer_idx <- 0, next state LOAD.
//  layer_idx never wraps; it is bounded by num_layers_q (<= 2^LAYER_W-1).
//  trace_state = state.
// TESTING
//  1. Reset, idle inputs -> all outputs 0, trace_state=0, layer_idx=0.
//  2. LOAD, w_load_val=1, sel=2 -> w_fifo_wen=4'b0100 in that cycle;
//     mac_val during MAC -> ignored.
//  3. num_layers=1; 3 beats available, then all empty -> istream_val high
//     3 cycles, DRAIN 3 cycles, OUT; rdy after 2 cycles -> acc_clr pulse,
//     then done=1 for 1 cycle, back to LOAD.
//  4. MAC with only w_fifo_empty[1]=1 -> istream/ren=0; state stays MAC
//     until the flag clears.
//  5. num_layers=3 -> layer_idx sequence 0,1,2; x_sel=1 in LOAD for layers
//     1 and 2; exactly one done pulse; num_layers=0 behaves as 1.
//  6. rst asserted in DRAIN and in OUT -> next cycle LOAD, layer_idx=0,
//     no done/acc_clr pulse.

Source files
------------

// File: rtl/tinynpu_layer_ctrl.sv
// rtl/tinynpu_layer_ctrl.sv - multi-layer load/MAC/drain/output sequencer for the TinyNPU datapath
module tinynpu_layer_ctrl #(
  parameter int SIZE    = 4,
  parameter int MAC_LAT = 3,
  parameter int LAYER_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    d2c_x_load_val,
  input  logic                    d2c_w_load_val,
  input  logic [$clog2(SIZE)-1:0] d2c_w_load_sel,
  input  logic                    d2c_mac_val,
  input  logic [LAYER_W-1:0]      d2c_num_layers,
  input  logic                    d2c_x_fifo_empty,
  input  logic [SIZE-1:0]         d2c_w_fifo_empty,
  input  logic                    d2c_ostream_rdy,
  output logic                    c2d_x_sel,
  output logic                    c2d_x_fifo_wen,
  output logic [SIZE-1:0]         c2d_w_fifo_wen,
  output logic                    c2d_istream_val,
  output logic                    c2d_x_fifo_ren,
  output logic                    c2d_w_fifo_ren,
  output logic                    c2d_ostream_req,
  output logic                    c2d_acc_clr,
  output logic                    c2d_done,
  output logic [LAYER_W-1:0]      c2d_layer_idx,
  output logic [2:0]              trace_state
);

  localparam int SEL_W = $clog2(SIZE);
  localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_MAC   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_idx_q, layer_idx_d;
  logic [LAYER_W-1:0] num_layers_q, num_layers_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               all_empty, any_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      layer_idx_q  <= '0;
      num_layers_q <= LAYER_W'(1);
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      layer_idx_q  <= layer_idx_d;
      num_layers_q <= num_layers_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign all_empty = d2c_x_fifo_empty & (&d2c_w_fifo_empty);
  assign any_empty = d2c_x_fifo_empty | (|d2c_w_fifo_empty);

  always_comb begin
    state_d         = state_q;
    layer_idx_d     = layer_idx_q;
    num_layers_d    = num_layers_q;
    drain_cnt_d     = drain_cnt_q;
    c2d_x_sel       = 1'b0;
    c2d_x_fifo_wen  = 1'b0;
    c2d_w_fifo_wen  = '0;
    c2d_istream_val = 1'b0;
    c2d_x_fifo_ren  = 1'b0;
    c2d_w_fifo_ren  = 1'b0;
    c2d_ostream_req = 1'b0;
    c2d_acc_clr     = 1'b0;
    c2d_done        = 1'b0;

    case (state_q)
      ST_LOAD: begin
        c2d_x_sel      = (layer_idx_q != '0);
        c2d_x_fifo_wen = d2c_x_load_val;
        for (int i = 0; i < SIZE; i++) begin
          c2d_w_fifo_wen[i] = d2c_w_load_val && (d2c_w_load_sel == SEL_W'(i));
        end
        if (d2c_mac_val) begin
          state_d = ST_MAC;
          // Layer count is latched only at the start of the first layer.
          if (layer_idx_q == '0) begin
            num_layers_d = (d2c_num_layers == '0) ? LAYER_W'(1) : d2c_num_layers;
          end
        end
      end
      ST_MAC: begin
        if (!any_empty) begin
          c2d_istream_val = 1'b1;
          c2d_x_fifo_ren  = 1'b1;
          c2d_w_fifo_ren  = 1'b1;
        end else if (all_empty) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == CNT_W'(MAC_LAT - 1)) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        c2d_ostream_req = 1'b1;
        if (d2c_ostream_rdy) begin
          c2d_acc_clr = 1'b1;
          if (({1'b0, layer_idx_q} + 1'b1) < {1'b0, num_layers_q}) begin
            layer_idx_d = layer_idx_q + 1'b1;
            state_d     = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        c2d_done    = 1'b1;
        layer_idx_d = '0;
        state_d     = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase

    // Reset silences every strobe even when the old state would assert one.
    if (rst) begin
      c2d_x_sel       = 1'b0;
      c2d_x_fifo_wen  = 1'b0;
      c2d_w_fifo_wen  = '0;
      c2d_istream_val = 1'b0;
      c2d_x_fifo_ren  = 1'b0;
      c2d_w_fifo_ren  = 1'b0;
      c2d_ostream_req = 1'b0;
      c2d_acc_clr     = 1'b0;
      c2d_done        = 1'b0;
    end
  end

  assign c2d_layer_idx = layer_idx_q;
  assign trace_state   = state_q;

endmodule

// File: tb/tb_tinynpu_layer_ctrl.sv
// tb/tb_tinynpu_layer_ctrl.sv - self-checking bench for tinynpu_layer_ctrl
module tb_tinynpu_layer_ctrl;
  localparam int SIZE = 4, MAC_LAT = 3, LAYER_W = 4;
  localparam logic [2:0] ST_LOAD = 3'd0, ST_MAC = 3'd1, ST_DRAIN = 3'd2, ST_OUT = 3'd3, ST_DONE = 3'd4;

  logic clk = 1'b0, rst;
  logic d2c_x_load_val, d2c_w_load_val, d2c_mac_val, d2c_x_fifo_empty, d2c_ostream_rdy;
  logic [1:0] d2c_w_load_sel;
  logic [LAYER_W-1:0] d2c_num_layers;
  logic [SIZE-1:0] d2c_w_fifo_empty;
  logic c2d_x_sel, c2d_x_fifo_wen, c2d_istream_val, c2d_x_fifo_ren, c2d_w_fifo_ren;
  logic c2d_ostream_req, c2d_acc_clr, c2d_done;
  logic [SIZE-1:0] c2d_w_fifo_wen;
  logic [LAYER_W-1:0] c2d_layer_idx;
  logic [2:0] trace_state;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  tinynpu_layer_ctrl #(.SIZE(SIZE), .MAC_LAT(MAC_LAT), .LAYER_W(LAYER_W)) dut (
    .clk(clk), .rst(rst),
    .d2c_x_load_val(d2c_x_load_val), .d2c_w_load_val(d2c_w_load_val), .d2c_w_load_sel(d2c_w_load_sel),
    .d2c_mac_val(d2c_mac_val), .d2c_num_layers(d2c_num_layers), .d2c_x_fifo_empty(d2c_x_fifo_empty),
    .d2c_w_fifo_empty(d2c_w_fifo_empty), .d2c_ostream_rdy(d2c_ostream_rdy),
    .c2d_x_sel(c2d_x_sel), .c2d_x_fifo_wen(c2d_x_fifo_wen), .c2d_w_fifo_wen(c2d_w_fifo_wen),
    .c2d_istream_val(c2d_istream_val), .c2d_x_fifo_ren(c2d_x_fifo_ren), .c2d_w_fifo_ren(c2d_w_fifo_ren),
    .c2d_ostream_req(c2d_ostream_req), .c2d_acc_clr(c2d_acc_clr), .c2d_done(c2d_done),
    .c2d_layer_idx(c2d_layer_idx), .trace_state(trace_state)
  );

  typedef struct packed {
    logic       mac, xload, wload, rdy;
    logic [1:0] wsel, emode;
    logic [2:0] st;
    logic       strm, req, acc, done, xsel;
    logic [3:0] idx;
  } cyc_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d2c_x_load_val = 0; d2c_w_load_val = 0; d2c_w_load_sel = 0; d2c_mac_val = 0;
    d2c_num_layers = 1; d2c_x_fifo_empty = 1; d2c_w_fifo_empty = '1; d2c_ostream_rdy = 0;
  endtask

  function automatic logic [11:0] outs();
    return {c2d_x_sel, c2d_x_fifo_wen, c2d_w_fifo_wen, c2d_istream_val, c2d_x_fifo_ren,
            c2d_w_fifo_ren, c2d_ostream_req, c2d_acc_clr, c2d_done};
  endfunction

  task automatic wait_state(input logic [2:0] st, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (trace_state == st) ok = 1;
      else tick();
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (3) begin
      tick();
      tests++;
      if ({c2d_done, c2d_acc_clr, c2d_ostream_req} !== 3'b000) begin
        fails++; $display("FAIL reset_pulse: got %b want 000", {c2d_done, c2d_acc_clr, c2d_ostream_req});
      end
    end
    rst = 0;
    #1;
    tests++; if (outs() !== 12'h0) begin fails++; $display("FAIL reset_outs: got %h want 000", outs()); end
    tests++; if (trace_state !== ST_LOAD) begin fails++; $display("FAIL reset_state: got %0d want 0", trace_state); end
    tests++; if (c2d_layer_idx !== 0) begin fails++; $display("FAIL reset_idx: got %0d want 0", c2d_layer_idx); end
    tick();
    tests++; if (outs() !== 12'h0) begin fails++; $display("FAIL idle_outs: got %h want 000", outs()); end
  endtask

  task automatic test_load();
    logic [3:0] exp_w;
    logic xl;
    bit ok;
    for (int s = 0; s < SIZE; s++) begin
      xl = 1'($urandom);
      d2c_x_load_val = xl; d2c_w_load_val = 1; d2c_w_load_sel = 2'(s);
      #1;
      exp_w = 4'b0001 << s;
      tests++;
      if ({c2d_x_fifo_wen, c2d_w_fifo_wen} !== {xl, exp_w}) begin
        fails++; $display("FAIL load_wen sel=%0d: got %b want %b", s, {c2d_x_fifo_wen, c2d_w_fifo_wen}, {xl, exp_w});
      end
      tick();
    end
    d2c_num_layers = 1; d2c_w_load_sel = 2; d2c_x_load_val = 0; d2c_mac_val = 1;
    #1;
    tests++; if (c2d_w_fifo_wen !== 4'b0100) begin fails++; $display("FAIL load_and_start: got %b want 0100", c2d_w_fifo_wen); end
    tick();
    d2c_x_fifo_empty = 0; d2c_w_fifo_empty = 4'b0001; d2c_x_load_val = 1;
    #1;
    tests++;
    if ({trace_state, c2d_x_fifo_wen, c2d_w_fifo_wen} !== {ST_MAC, 5'b0}) begin
      fails++; $display("FAIL mac_ignores_load: got %b want %b", {trace_state, c2d_x_fifo_wen, c2d_w_fifo_wen}, {ST_MAC, 5'b0});
    end
    tick();
    tests++; if (trace_state !== ST_MAC) begin fails++; $display("FAIL mac_ignores_start: got %0d want 1", trace_state); end
    idle(); d2c_ostream_rdy = 1;
    wait_state(ST_LOAD, ok);
    tests++; if (!ok) begin fails++; $display("FAIL load_return: got state %0d want 0", trace_state); end
    idle();
  endtask

  task automatic test_single_layer();
    d2c_num_layers = 1; d2c_mac_val = 1;
    tick();
    d2c_mac_val = 0; d2c_x_fifo_empty = 0; d2c_w_fifo_empty = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({trace_state, c2d_istream_val, c2d_x_fifo_ren, c2d_w_fifo_ren} !== {ST_MAC, 3'b000}) begin
        fails++; $display("FAIL stall: got %b want %b", {trace_state, c2d_istream_val, c2d_x_fifo_ren, c2d_w_fifo_ren}, {ST_MAC, 3'b000});
      end
      tick();
    end
    d2c_w_fifo_empty = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({c2d_istream_val, c2d_x_fifo_ren, c2d_w_fifo_ren} !== 3'b111) begin
        fails++; $display("FAIL beat%0d: got %b want 111", i, {c2d_istream_val, c2d_x_fifo_ren, c2d_w_fifo_ren});
      end
      tick();
    end
    d2c_x_fifo_empty = 1; d2c_w_fifo_empty = '1;
    #1;
    tests++; if (c2d_istream_val !== 0) begin fails++; $display("FAIL empty_beat: got %b want 0", c2d_istream_val); end
    tick();
    for (int i = 0; i < MAC_LAT; i++) begin
      tests++; if (trace_state !== ST_DRAIN) begin fails++; $display("FAIL drain%0d: got %0d want 2", i, trace_state); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if ({trace_state, c2d_ostream_req, c2d_acc_clr} !== {ST_OUT, 2'b10}) begin
        fails++; $display("FAIL out_wait: got %b want %b", {trace_state, c2d_ostream_req, c2d_acc_clr}, {ST_OUT, 2'b10});
      end
      tick();
    end
    d2c_ostream_rdy = 1;
    #1;
    tests++; if ({c2d_ostream_req, c2d_acc_clr} !== 2'b11) begin fails++; $display("FAIL handshake: got %b want 11", {c2d_ostream_req, c2d_acc_clr}); end
    tick();
    d2c_ostream_rdy = 0;
    #1;
    tests++; if ({trace_state, c2d_done} !== {ST_DONE, 1'b1}) begin fails++; $display("FAIL done: got %b want %b", {trace_state, c2d_done}, {ST_DONE, 1'b1}); end
    tick();
    tests++; if ({trace_state, c2d_done} !== {ST_LOAD, 1'b0}) begin fails++; $display("FAIL after_done: got %b want %b", {trace_state, c2d_done}, {ST_LOAD, 1'b0}); end
  endtask

  function automatic cyc_t rnd_cyc(logic [2:0] st, logic [3:0] idx);
    cyc_t c = '0;
    c.mac = 1'($urandom); c.xload = 1'($urandom); c.wload = 1'($urandom); c.rdy = 1'($urandom);
    c.wsel = 2'($urandom); c.emode = 2'($urandom);
    c.st = st; c.idx = idx;
    return c;
  endfunction

  task automatic test_multi_layer(input int iters);
    cyc_t q[$];
    cyc_t c;
    logic [LAYER_W-1:0] nl_in;
    logic [4:0] exp_wen, wmask;
    int n, nload, beats, stalls, wait_r;
    for (int it = 0; it < iters; it++) begin
      nl_in = (it == 0) ? 4'd0 : (it == 1) ? 4'd3 : 4'($urandom_range(1, 5));
      n = (nl_in == 0) ? 1 : int'(nl_in);
      q = {};
      for (int l = 0; l < n; l++) begin
        nload = $urandom_range(0, 2);
        for (int j = 0; j <= nload; j++) begin
          c = rnd_cyc(ST_LOAD, 4'(l)); c.xsel = (l != 0); c.mac = (j == nload); q.push_back(c);
        end
        beats = $urandom_range(0, 4);
        stalls = (beats > 0) ? $urandom_range(0, 2) : 0;
        for (int j = 0; j < stalls + beats + 1; j++) begin
          c = rnd_cyc(ST_MAC, 4'(l));
          c.emode = (j < stalls) ? 2'd1 : (j < stalls + beats) ? 2'd0 : 2'd2;
          c.strm = (j >= stalls) && (j < stalls + beats);
          q.push_back(c);
        end
        for (int j = 0; j < MAC_LAT; j++) q.push_back(rnd_cyc(ST_DRAIN, 4'(l)));
        wait_r = $urandom_range(0, 3);
        for (int j = 0; j <= wait_r; j++) begin
          c = rnd_cyc(ST_OUT, 4'(l)); c.req = 1; c.rdy = (j == wait_r); c.acc = c.rdy; q.push_back(c);
        end
      end
      c = rnd_cyc(ST_DONE, 4'(n - 1)); c.done = 1; q.push_back(c);
      c = rnd_cyc(ST_LOAD, 4'd0); c.mac = 0; q.push_back(c);

      for (int i = 0; i < q.size(); i++) begin
        c = q[i];
        d2c_mac_val = c.mac; d2c_x_load_val = c.xload; d2c_w_load_val = c.wload;
        d2c_w_load_sel = c.wsel; d2c_ostream_rdy = c.rdy;
        d2c_num_layers = (c.st == ST_LOAD && c.mac && c.idx == 0) ? nl_in : LAYER_W'($urandom);
        case (c.emode)
          2'd0: {d2c_x_fifo_empty, d2c_w_fifo_empty} = 5'b00000;
          2'd1: {d2c_x_fifo_empty, d2c_w_fifo_empty} = 5'($urandom_range(1, 30));
          default: {d2c_x_fifo_empty, d2c_w_fifo_empty} = 5'b11111;
        endcase
        wmask = c.wload ? (5'b00001 << c.wsel) : 5'b0;
        exp_wen = (c.st == ST_LOAD) ? ({c.xload, 4'b0} | wmask) : 5'b0;
        #1;
        tests++;
        if (trace_state !== c.st) begin
          fails++; $display("FAIL ml_state it=%0d cyc=%0d: got %0d want %0d", it, i, trace_state, c.st);
          rst = 1; tick(); rst = 0;
          break;
        end
        tests++;
        if ({c2d_istream_val, c2d_x_fifo_ren, c2d_w_fifo_ren} !== {3{c.strm}}) begin
          fails++; $display("FAIL ml_stream it=%0d cyc=%0d: got %b want %b", it, i, {c2d_istream_val, c2d_x_fifo_ren, c2d_w_fifo_ren}, {3{c.strm}});
        end
        tests++;
        if ({c2d_x_fifo_wen, c2d_w_fifo_wen} !== exp_wen) begin
          fails++; $display("FAIL ml_wen it=%0d cyc=%0d: got %b want %b", it, i, {c2d_x_fifo_wen, c2d_w_fifo_wen}, exp_wen);
        end
        tests++;
        if ({c2d_ostream_req, c2d_acc_clr, c2d_done} !== {c.req, c.acc, c.done}) begin
          fails++; $display("FAIL ml_out it=%0d cyc=%0d: got %b want %b", it, i, {c2d_ostream_req, c2d_acc_clr, c2d_done}, {c.req, c.acc, c.done});
        end
        tests++;
        if ({c2d_layer_idx, c2d_x_sel} !== {c.idx, c.xsel}) begin
          fails++; $display("FAIL ml_idx it=%0d cyc=%0d: got %h want %h", it, i, {c2d_layer_idx, c2d_x_sel}, {c.idx, c.xsel});
        end
        tick();
      end
    end
    idle();
  endtask

  task automatic test_reset_abort();
    bit ok;
    idle(); d2c_num_layers = 1; d2c_mac_val = 1;
    tick();
    d2c_mac_val = 0;
    tick();
    tests++; if (trace_state !== ST_DRAIN) begin fails++; $display("FAIL abort_reach_drain: got %0d want 2", trace_state); end
    rst = 1; d2c_ostream_rdy = 1;
    #1;
    tests++; if (outs() !== 12'h0) begin fails++; $display("FAIL abort_drain_pulse: got %h want 000", outs()); end
    tick();
    rst = 0; d2c_ostream_rdy = 0;
    #1;
    tests++; if ({trace_state, c2d_layer_idx, outs()} !== 19'h0) begin fails++; $display("FAIL abort_drain_after: got %h want 0", {trace_state, c2d_layer_idx, outs()}); end

    d2c_num_layers = 3; d2c_mac_val = 1;
    tick();
    d2c_mac_val = 0;
    wait_state(ST_OUT, ok);
    d2c_ostream_rdy = 1;
    tick();
    d2c_ostream_rdy = 0;
    #1;
    tests++; if ({ok, trace_state, c2d_layer_idx, c2d_x_sel} !== {1'b1, ST_LOAD, 4'd1, 1'b1}) begin
      fails++; $display("FAIL abort_layer1: got %h want %h", {ok, trace_state, c2d_layer_idx, c2d_x_sel}, {1'b1, ST_LOAD, 4'd1, 1'b1});
    end
    d2c_mac_val = 1;
    tick();
    d2c_mac_val = 0;
    wait_state(ST_OUT, ok);
    rst = 1; d2c_ostream_rdy = 1;
    #1;
    tests++; if ({ok, c2d_acc_clr, c2d_done, c2d_ostream_req} !== 4'b1000) begin
      fails++; $display("FAIL abort_out_pulse: got %b want 1000", {ok, c2d_acc_clr, c2d_done, c2d_ostream_req});
    end
    tick();
    rst = 0; d2c_ostream_rdy = 0;
    #1;
    tests++; if ({trace_state, c2d_layer_idx, c2d_x_sel} !== 8'h0) begin fails++; $display("FAIL abort_out_after: got %h want 00", {trace_state, c2d_layer_idx, c2d_x_sel}); end
    tick();
    tests++; if ({trace_state, c2d_done} !== 4'h0) begin fails++; $display("FAIL abort_no_done: got %h want 0", {trace_state, c2d_done}); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_single_layer();
    test_multi_layer(8);
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
